// File: rtl/legv8_decode_regfile.sv
// LEGv8 decode stage with a 32x32 register file: combinational decode and reads,
// synchronous write-back, X31 hard-wired to zero, asynchronous clear.
module legv8_decode_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] write_data,
  output logic [4:0]  register1,
  output logic [4:0]  register2,
  output logic [4:0]  write_register,
  output logic [31:0] immediate,
  output logic        reg2loc,
  output logic        uncondbranch,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic [31:0] data1,
  output logic [31:0] data2
);

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [8:0]  OP_MOVZ = 9'b111100101;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [4:0]  XZR     = 5'd31;
  localparam logic [4:0]  LINK    = 5'd30;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        is_bl_s;
  logic        is_rtype_s;
  logic [31:0] rd2_s;

  assign is_bl_s    = (instruction[31:26] == OP_BL);
  assign is_rtype_s = (instruction[31:21] == OP_ADD) || (instruction[31:21] == OP_SUB) ||
                      (instruction[31:21] == OP_AND) || (instruction[31:21] == OP_ORR);

  // Main control and immediate extraction; opcodes are mutually exclusive.
  always_comb begin
    reg2loc      = 1'b0;
    uncondbranch = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_to_reg   = 1'b0;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    alu_op       = 2'b00;
    immediate    = 32'd0;
    if (instruction[31:26] == OP_B) begin
      uncondbranch = 1'b1;
      immediate    = {{6{instruction[25]}}, instruction[25:0]};
    end else if (is_bl_s) begin
      uncondbranch = 1'b1;
      reg_write    = 1'b1;
      immediate    = {{6{instruction[25]}}, instruction[25:0]};
    end else if ((instruction[31:24] == OP_CBZ) || (instruction[31:24] == OP_CBNZ)) begin
      reg2loc   = 1'b1;
      branch    = 1'b1;
      alu_op    = 2'b01;
      immediate = {{13{instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:23] == OP_MOVZ) begin
      alu_src   = 1'b1;
      reg_write = 1'b1;
      alu_op    = 2'b11;
      immediate = {16'd0, instruction[20:5]};
    end else if ((instruction[31:22] == OP_ADDI) || (instruction[31:22] == OP_SUBI)) begin
      alu_src   = 1'b1;
      reg_write = 1'b1;
      alu_op    = 2'b10;
      immediate = {{20{instruction[21]}}, instruction[21:10]};
    end else if (is_rtype_s) begin
      reg_write = 1'b1;
      alu_op    = 2'b10;
    end else if (instruction[31:21] == OP_LDUR) begin
      alu_src    = 1'b1;
      mem_to_reg = 1'b1;
      reg_write  = 1'b1;
      mem_read   = 1'b1;
      immediate  = {{23{instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:21] == OP_STUR) begin
      reg2loc   = 1'b1;
      alu_src   = 1'b1;
      mem_write = 1'b1;
      immediate = {{23{instruction[20]}}, instruction[20:12]};
    end else begin
      immediate = 32'd0;
    end
  end

  assign register1      = instruction[9:5];
  assign register2      = reg2loc ? instruction[4:0] : instruction[20:16];
  assign write_register = is_bl_s ? LINK : instruction[4:0];

  // X31 is never written, but reads force zero regardless of array contents.
  assign data1 = (register1 == XZR) ? 32'd0 : regs_q[register1];
  assign rd2_s = (register2 == XZR) ? 32'd0 : regs_q[register2];
  assign data2 = alu_src ? immediate : rd2_s;

  // Next-state of the register array: one entry updated on write-back.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      if (reg_write && (write_register != XZR) && (write_register == 5'(i))) begin
        regs_d[i] = write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array state; reset clears everything and blocks writes while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_legv8_decode_regfile.sv
// Randomized self-checking bench for legv8_decode_regfile: behavioural decode and
// register model, per-cycle comparison, plus literal vectors pinning the model.
module tb_legv8_decode_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [4:0]  register1, register2, write_register;
  logic [31:0] immediate, data1, data2;
  logic        reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;

  int n_pass = 0;
  int n_total = 0;

  legv8_decode_regfile dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .write_data(write_data),
    .register1(register1), .register2(register2), .write_register(write_register),
    .immediate(immediate), .reg2loc(reg2loc), .uncondbranch(uncondbranch), .branch(branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .alu_op(alu_op), .data1(data1), .data2(data2)
  );

  always #5 clk = ~clk;

  // ctrl = {reg2loc,uncondbranch,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op}
  typedef struct packed {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [31:0] imm;
    logic [9:0]  ctrl;
  } dec_t;

  function automatic int field(input int unsigned u, input int lo, input int n);
    return int'((u >> lo) % (32'd1 << n));
  endfunction

  function automatic int sx(input int v, input int n);
    if (v >= (1 << (n - 1))) return v - (1 << n);
    else return v;
  endfunction

  function automatic dec_t model_dec(input logic [31:0] ins);
    dec_t d;
    int unsigned u;
    int imm;
    bit bl;
    u = ins;
    imm = 0;
    bl = 1'b0;
    d.ctrl = 10'b0000000000;
    if ((u >> 26) == 5) begin
      d.ctrl = 10'b0100000000; imm = sx(field(u, 0, 26), 26);
    end else if ((u >> 26) == 37) begin
      d.ctrl = 10'b0100000100; imm = sx(field(u, 0, 26), 26); bl = 1'b1;
    end else if ((u >> 24) == 180 || (u >> 24) == 181) begin
      d.ctrl = 10'b1010000001; imm = sx(field(u, 5, 19), 19);
    end else if ((u >> 23) == 485) begin
      d.ctrl = 10'b0000001111; imm = field(u, 5, 16);
    end else if ((u >> 22) == 580 || (u >> 22) == 836) begin
      d.ctrl = 10'b0000001110; imm = sx(field(u, 10, 12), 12);
    end else if ((u >> 21) == 1112 || (u >> 21) == 1624 || (u >> 21) == 1104 || (u >> 21) == 1360) begin
      d.ctrl = 10'b0000000110;
    end else if ((u >> 21) == 1986) begin
      d.ctrl = 10'b0001101100; imm = sx(field(u, 12, 9), 9);
    end else if ((u >> 21) == 1984) begin
      d.ctrl = 10'b1000011000; imm = sx(field(u, 12, 9), 9);
    end else begin
      d.ctrl = 10'b0000000000;
    end
    d.imm = imm;
    d.r1  = 5'(field(u, 5, 5));
    d.r2  = d.ctrl[9] ? 5'(field(u, 0, 5)) : 5'(field(u, 16, 5));
    d.wr  = bl ? 5'd30 : 5'(field(u, 0, 5));
    return d;
  endfunction

  dec_t cur_d;
  assign cur_d = model_dec(instruction);

  logic [31:0] mregs [32];

  // Architectural register model: X31 is never stored, reset clears asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
    end else if (cur_d.ctrl[2] && cur_d.wr != 5'd31) begin
      mregs[cur_d.wr] <= write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  logic [31:0] exp_d2;
  assign exp_d2 = cur_d.ctrl[3] ? cur_d.imm : mregs[cur_d.r2];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("register1", {27'd0, register1}, {27'd0, cur_d.r1});
    chk("register2", {27'd0, register2}, {27'd0, cur_d.r2});
    chk("write_register", {27'd0, write_register}, {27'd0, cur_d.wr});
    chk("immediate", immediate, cur_d.imm);
    chk("controls", {22'd0, reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
                     alu_src, reg_write, alu_op}, {22'd0, cur_d.ctrl});
    chk("data1", data1, mregs[cur_d.r1]);
    chk("data2", data2, exp_d2);
  end

  task automatic apply(input logic [31:0] ins, input logic [31:0] wd);
    @(posedge clk);
    #2;
    instruction = ins;
    write_data  = wd;
    #1;
  endtask

  logic [31:0] r, ins;
  int k;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    apply(32'h17FFFFFF, 32'd0);
    chk("B ub", {31'd0, uncondbranch}, 32'd1);
    chk("B imm", immediate, 32'hFFFFFFFF);
    apply(32'h94202002, 32'd0);
    chk("BL imm", immediate, 32'd2105346);
    chk("BL wr", {27'd0, write_register}, 32'd30);
    chk("BL rw", {31'd0, reg_write}, 32'd1);
    apply(32'hB42D3945, 32'd0);
    chk("CBZ ctl", {29'd0, branch, reg2loc, alu_op == 2'b01}, 32'd7);
    chk("CBZ r2", {27'd0, register2}, 32'd5);
    chk("CBZ imm", immediate, 32'd92618);
    apply(32'hB5D2C6C3, 32'd0);
    chk("CBNZ r2", {27'd0, register2}, 32'd3);
    chk("CBNZ imm", immediate, -32'sd92618);
    apply(32'h8A040041, 32'd0);
    chk("AND idx", {17'd0, register1, register2, write_register}, {17'd0, 5'd2, 5'd4, 5'd1});
    chk("AND ctl", {29'd0, reg_write, alu_op}, 32'b110);
    chk("AND as", {31'd0, alu_src}, 32'd0);
    apply(32'hF81B8044, 32'd0);
    chk("STUR ctl", {30'd0, reg2loc, mem_write}, 32'd3);
    chk("STUR r2", {27'd0, register2}, 32'd4);
    chk("STUR imm", immediate, -32'sd72);
    chk("STUR d2", data2, -32'sd72);
    apply(32'hF8462060, 32'd0);
    chk("LDUR ctl", {30'd0, mem_read, mem_to_reg}, 32'd3);
    chk("LDUR idx", {22'd0, register1, write_register}, {22'd0, 5'd3, 5'd0});
    chk("LDUR imm", immediate, 32'd98);
    apply(32'h913E03E0, 32'd0);
    chk("ADDI r1", {27'd0, register1}, 32'd31);
    chk("ADDI d1", data1, 32'd0);
    chk("ADDI imm", immediate, -32'sd128);
    chk("ADDI as", {31'd0, alu_src}, 32'd1);
    apply(32'hF28000E2, 32'd0);
    chk("MOVZ imm", immediate, 32'd7);
    chk("MOVZ wr", {27'd0, write_register}, 32'd2);
    chk("MOVZ op", {30'd0, alu_op}, 32'd3);

    apply(32'h910000A5, 32'hDEADBEEF);
    chk("pre-edge d1", data1, 32'd0);
    apply(32'h8A0500A1, 32'd0);
    chk("X5 d1", data1, 32'hDEADBEEF);
    chk("X5 d2", data2, 32'hDEADBEEF);
    apply(32'h9100001F, 32'h00000055);
    apply(32'h8B1F03E0, 32'd0);
    chk("XZR d1", data1, 32'd0);
    chk("XZR d2", data2, 32'd0);

    apply(32'h910000E7, 32'h00001234);
    apply(32'h8B0700E0, 32'd0);
    chk("X7 written", data1, 32'h00001234);
    #1 rst_n = 1'b0;
    #1 chk("X7 async clear", data1, 32'd0);
    instruction = 32'h910000E7;
    write_data  = 32'h00009999;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("write in reset", data1, 32'd0);

    for (int n = 0; n < 800; n++) begin
      r = $urandom;
      k = $urandom_range(0, 12);
      case (k)
        0:  ins = {6'b000101, r[25:0]};
        1:  ins = {6'b100101, r[25:0]};
        2:  ins = {8'b10110100, r[23:0]};
        3:  ins = {8'b10110101, r[23:0]};
        4:  ins = {9'b111100101, r[22:0]};
        5:  ins = {10'b1001000100, r[21:0]};
        6:  ins = {10'b1101000100, r[21:0]};
        7:  ins = {11'b10001011000, r[20:0]};
        8:  ins = {11'b11001011000, r[20:0]};
        9:  ins = {r[31] ? 11'b10001010000 : 11'b10101010000, r[20:0]};
        10: ins = {11'b11111000010, r[20:0]};
        11: ins = {11'b11111000000, r[20:0]};
        default: ins = r;
      endcase
      apply(ins, $urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/legv8_decode_regfile.md
Name: legv8_decode_regfile

Overview:
- Combined instruction-decode stage and 32x32 register file for a single-cycle LEGv8 datapath.
- Decodes a 32-bit instruction into register indices, a sign/zero-extended immediate and main-control signals.
- Reads two operands. Operand 2 is muxed with the immediate.
- Writes external write-back data on the clock edge.

Parameters:
- None. Data width is fixed at 32. Register count is fixed at 32.

Ports:
- clk  in  1  rising-edge clock for register writes
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  current instruction
- write_data  in  32  write-back value (ALU/memory result or link address)
- register1  out  5  read index 1
- register2  out  5  read index 2
- write_register  out  5  destination index
- immediate  out  32  extended immediate (signed)
- reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control signals
- alu_op  out  2  ALU control class
- data1  out  32  operand 1, always regs[register1]
- data2  out  32  operand 2, alu_src ? immediate : regs[register2]

Behaviour:
- Decoder and read paths are purely combinational, with zero latency. Only register contents are state.
- Index fields:
  - register1 = instr[9:5].
  - register2 = reg2loc ? instr[4:0] : instr[20:16].
  - write_register = instr[4:0], except BL, which forces 30.
- Opcode match is exact. Each instruction sets the listed controls; all other controls are 0.
  - B, instr[31:26]=000101: uncondbranch=1. immediate = sext(instr[25:0]).
  - BL, instr[31:26]=100101: uncondbranch=1, reg_write=1. immediate = sext(instr[25:0]).
  - CBZ, instr[31:24]=10110100: reg2loc=1, branch=1, alu_op=01. immediate = sext(instr[23:5]).
  - CBNZ, instr[31:24]=10110101: same controls and immediate as CBZ.
  - MOVZ, instr[31:23]=111100101: alu_src=1, reg_write=1, alu_op=11. immediate = zext(instr[20:5]).
  - ADDI, instr[31:22]=1001000100: alu_src=1, reg_write=1, alu_op=10. immediate = sext(instr[21:10]).
  - SUBI, instr[31:22]=1101000100: same controls and immediate as ADDI.
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (instr[31:21]): reg_write=1, alu_op=10. immediate = 0.
  - LDUR, instr[31:21]=11111000010: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00. immediate = sext(instr[20:12]).
  - STUR, instr[31:21]=11111000000: reg2loc=1, alu_src=1, mem_write=1, alu_op=00. immediate = sext(instr[20:12]).
  - Any other encoding: all controls 0, alu_op=00, immediate=0. Index fields still follow the rules above.
- Immediates are not scaled; they are emitted exactly as encoded.
- Register file:
  - Write is synchronous on rising clk when reg_write=1 and write_register != 31.
  - X31 (XZR) always reads 0; writes to it are discarded.
  - No write-to-read bypass: the new value is visible only after the clock edge. A same-cycle read returns the old value.
  - Asynchronous reset clears all registers to 0 immediately and holds them while rst_n=0. Writes are blocked during reset.
  - Reset asserted mid-write: the write is lost.
  - Reset values: data1 = data2 = 0, except data2 = immediate when alu_src=1. Decoder outputs track instruction during reset.

Test Plan:
- Decode immediates, rst_n=1:
  - 0x17FFFFFF -> uncondbranch=1, immediate=-1.
  - 0x94202002 -> immediate=2105346, write_register=30, reg_write=1.
  - 0xB42D3945 -> branch=1, reg2loc=1, register2=5, immediate=92618, alu_op=01.
  - 0xB5D2C6C3 -> register2=3, immediate=-92618.
- R-type 0x8A040041 (AND X1,X2,X4) -> register1=2, register2=4, write_register=1, reg_write=1, alu_op=10, alu_src=0.
- D-type:
  - 0xF81B8044 (STUR) -> reg2loc=1, mem_write=1, register2=4, immediate=-72, data2=-72.
  - 0xF8462060 (LDUR) -> mem_read=1, mem_to_reg=1, register1=3, write_register=0, immediate=98.
- I/IW-type:
  - 0x913E03E0 -> register1=31, data1=0, immediate=-128, alu_src=1.
  - 0xF28000E2 -> immediate=7, write_register=2, alu_op=11.
- Write/read and XZR:
  - Apply ADDI X5 with write_data=0xDEADBEEF and one clk edge; then apply AND X1,X5,X5 (0x8A0500A1) -> data1=data2=0xDEADBEEF.
  - A write to X31 leaves X31 reading 0.
  - Before the edge, data1 shows the old value.
- Reset: write X7=0x1234, then pulse rst_n low asynchronously between edges -> data1 for X7 reads 0 immediately. A write attempted while rst_n=0 has no effect.
